// File: rtl/sha2_msg_schedule.sv
`timescale 1ns/1ps
// sha2_msg_schedule: SHA-2 message schedule generator.
// Takes the 16 words of one block serially and streams W[0..ROUNDS-1]
// on a registered valid/ready output, one word per accepted output beat.
// WORDSIZE 32 selects the SHA-224/256 sigmas; 64 selects the SHA-384/512 sigmas.
// Optional build macro SHA2_SCHED_ABORT_EN adds a synchronous 'abort' input.
//
// state  | meaning
// LOAD   | accepting message words 0..15, each echoed out as W[t]
// EXPAND | producing W[16..ROUNDS-1] from the 16-word sliding window
module sha2_msg_schedule #(
  parameter int WORDSIZE = 32,
  parameter int ROUNDS   = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WORDSIZE-1:0] in_word,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORDSIZE-1:0] out_w,
  output logic [6:0]          out_idx,
  output logic                out_last,
  output logic                busy
`ifdef SHA2_SCHED_ABORT_EN
  ,
  input  logic                abort
`endif
);

  typedef enum logic {LOAD, EXPAND} state_t;

  localparam logic [6:0] LAST_T = 7'(ROUNDS - 1);

  state_t              state;
  logic [6:0]          t;
  logic [WORDSIZE-1:0] win [16];   // win[0] = W[t-16] (oldest), win[15] = W[t-1]
  logic                slot_free;
  logic                accept;
  logic                step;
  logic                last_hs;
  logic                abort_i;
  logic [WORDSIZE-1:0] s0;
  logic [WORDSIZE-1:0] s1;
  logic [WORDSIZE-1:0] new_w;

`ifdef SHA2_SCHED_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  // The output register can take a new word when empty or being drained now.
  assign slot_free = !out_valid || out_ready;
  assign in_ready  = (state == LOAD) && slot_free && !abort_i;
  assign accept    = in_valid && in_ready;
  assign step      = (state == EXPAND) && slot_free && !abort_i;
  assign last_hs   = out_valid && out_ready && out_last;

  generate
    if (WORDSIZE == 64) begin : g_sig64
      assign s0 = {win[1][0], win[1][63:1]} ^ {win[1][7:0], win[1][63:8]} ^ (win[1] >> 7);
      assign s1 = {win[14][18:0], win[14][63:19]} ^ {win[14][60:0], win[14][63:61]} ^ (win[14] >> 6);
    end else begin : g_sig32
      assign s0 = {win[1][6:0], win[1][31:7]} ^ {win[1][17:0], win[1][31:18]} ^ (win[1] >> 3);
      assign s1 = {win[14][16:0], win[14][31:17]} ^ {win[14][18:0], win[14][31:19]} ^ (win[14] >> 10);
    end
  endgenerate

  // Wraps modulo 2^WORDSIZE by construction.
  assign new_w = s1 + win[9] + s0 + win[0];

  // Sequencer, sliding window and registered output stream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOAD;
      t         <= '0;
      out_valid <= 1'b0;
      out_w     <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else if (abort_i) begin
      // Window is left as is: the next block refills all 16 slots before use.
      state     <= LOAD;
      t         <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (accept || step) begin
        out_w     <= accept ? in_word : new_w;
        out_idx   <= t;
        out_last  <= (t == LAST_T);
        out_valid <= 1'b1;
        for (int i = 0; i < 15; i++) win[i] <= win[i+1];
        win[15] <= accept ? in_word : new_w;
        if (t == LAST_T) begin
          state <= LOAD;
          t     <= '0;
        end else begin
          t <= t + 7'd1;
          if (t == 7'd15) state <= EXPAND;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      // A word 0 accepted alongside the last handshake keeps busy asserted.
      if (accept) busy <= 1'b1;
      else if (last_hs) busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sha2_msg_schedule.sv
`timescale 1ns/1ps
// Bench for sha2_msg_schedule: one 32-bit (SHA-256) and one 64-bit (SHA-512)
// instance, a software schedule model and an expected-word queue.
module tb_sha2_msg_schedule;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b0;

  logic        in_valid32, in_ready32, out_valid32, out_ready32, out_last32, busy32;
  logic [31:0] in_word32, out_w32;
  logic [6:0]  out_idx32;
  logic        in_valid64, in_ready64, out_valid64, out_ready64, out_last64, busy64;
  logic [63:0] in_word64, out_w64;
  logic [6:0]  out_idx64;
`ifdef SHA2_SCHED_ABORT_EN
  logic        abort32 = 1'b0;
  logic        abort64 = 1'b0;
`endif

  sha2_msg_schedule #(.WORDSIZE(32), .ROUNDS(64)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32), .in_word(in_word32),
    .out_valid(out_valid32), .out_ready(out_ready32), .out_w(out_w32), .out_idx(out_idx32),
    .out_last(out_last32), .busy(busy32)
`ifdef SHA2_SCHED_ABORT_EN
    , .abort(abort32)
`endif
  );

  sha2_msg_schedule #(.WORDSIZE(64), .ROUNDS(80)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid64), .in_ready(in_ready64), .in_word(in_word64),
    .out_valid(out_valid64), .out_ready(out_ready64), .out_w(out_w64), .out_idx(out_idx64),
    .out_last(out_last64), .busy(busy64)
`ifdef SHA2_SCHED_ABORT_EN
    , .abort(abort64)
`endif
  );

  // Width-neutral view of whichever instance is under test.
  bit          use64 = 1'b0;
  logic        o_valid, o_ready, o_last, o_busy, o_in_valid, o_in_ready;
  logic [63:0] o_w;
  logic [6:0]  o_idx;
  assign o_valid    = use64 ? out_valid64 : out_valid32;
  assign o_ready    = use64 ? out_ready64 : out_ready32;
  assign o_last     = use64 ? out_last64  : out_last32;
  assign o_busy     = use64 ? busy64      : busy32;
  assign o_in_valid = use64 ? in_valid64  : in_valid32;
  assign o_in_ready = use64 ? in_ready64  : in_ready32;
  assign o_w        = use64 ? out_w64     : {32'h0, out_w32};
  assign o_idx      = use64 ? out_idx64   : out_idx32;

  typedef struct {
    logic [63:0] w;
    logic [6:0]  idx;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] msg   [2][16];
  logic [63:0] model [2][80];
  logic [63:0] obs   [256];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          hs_cnt;
  int          last_cyc;
  bit          b2b_same;

  // ---------------- software model ----------------
  function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input bit is64);
    logic [31:0] a;
    if (is64) return (x >> n) | (x << (64 - n));
    a = (x[31:0] >> n) | (x[31:0] << (32 - n));
    return {32'h0, a};
  endfunction

  function automatic logic [63:0] sig0(input logic [63:0] x, input bit is64);
    if (is64) return rotr(x, 1, 1'b1) ^ rotr(x, 8, 1'b1) ^ (x >> 7);
    return rotr(x, 7, 1'b0) ^ rotr(x, 18, 1'b0) ^ (x >> 3);
  endfunction

  function automatic logic [63:0] sig1(input logic [63:0] x, input bit is64);
    if (is64) return rotr(x, 19, 1'b1) ^ rotr(x, 61, 1'b1) ^ (x >> 6);
    return rotr(x, 17, 1'b0) ^ rotr(x, 19, 1'b0) ^ (x >> 10);
  endfunction

  function automatic void build_model(input int b, input bit is64);
    logic [63:0] s;
    for (int j = 0; j < 16; j++) model[b][j] = msg[b][j];
    for (int j = 16; j < 80; j++) begin
      s = sig1(model[b][j-2], is64) + model[b][j-7] + sig0(model[b][j-15], is64) + model[b][j-16];
      if (!is64) s[63:32] = 32'h0;
      model[b][j] = s;
    end
  endfunction

  function automatic void load_abc(input int b, input bit is64);
    for (int k = 0; k < 16; k++) msg[b][k] = 64'h0;
    msg[b][0]  = is64 ? 64'h6162638000000000 : 64'h0000000061626380;
    msg[b][15] = 64'h18;
  endfunction

  function automatic void load_random(input int b);
    for (int k = 0; k < 16; k++) msg[b][k] = {32'h0, $urandom};
  endfunction

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input logic [63:0] d, input bit r);
    if (use64) begin
      in_valid64 = v; in_word64 = d; out_ready64 = r;
      in_valid32 = 1'b0; in_word32 = 32'h0; out_ready32 = 1'b1;
    end else begin
      in_valid32 = v; in_word32 = d[31:0]; out_ready32 = r;
      in_valid64 = 1'b0; in_word64 = 64'h0; out_ready64 = 1'b1;
    end
  endtask

  // Feeds nblk blocks and checks every output beat against the queue.
  // Called and returns just after a rising edge.
  task automatic stream(input int nblk, input bit rand_ready);
    int          rounds, in_ptr, cyc, blk, k;
    bit          stalled, busy_exp, acc, hsv, r;
    logic [63:0] hw;
    logic [6:0]  hi;
    logic        hl;
    exp_t        e;
    rounds = use64 ? 80 : 64;
    in_ptr = 0; cyc = 0; stalled = 1'b0; busy_exp = 1'b0;
    hw = 64'h0; hi = 7'h0; hl = 1'b0;
    hs_cnt = 0; b2b_same = 1'b0;
    sb.delete();
    r = rand_ready ? ($urandom_range(0, 1) != 0) : 1'b1;
    drive(1'b1, msg[0][0], r);
    while (hs_cnt < nblk * rounds && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      acc = o_in_valid && o_in_ready;
      hsv = o_valid && o_ready;
      if (stalled) begin
        n_checks++;
        if (o_w !== hw || o_idx !== hi || o_last !== hl) begin
          n_fail++;
          $display("FAIL stall_hold: got w=%h idx=%0d last=%b, held w=%h idx=%0d last=%b", o_w, o_idx, o_last, hw, hi, hl);
        end
      end
      if (o_valid && !o_ready) begin
        n_checks++;
        if (o_in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_in_ready: got %b, want 0", o_in_ready);
        end
      end
      n_checks++;
      if (o_busy !== busy_exp) begin
        n_fail++;
        $display("FAIL busy: got %b, want %b at cycle %0d", o_busy, busy_exp, cyc);
      end
      if (o_valid) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_word: got w=%h idx=%0d with empty queue", o_w, o_idx);
        end else begin
          e = sb[0];
          if (o_w !== e.w || o_idx !== e.idx || o_last !== e.last) begin
            n_fail++;
            $display("FAIL word: got w=%h idx=%0d last=%b, want w=%h idx=%0d last=%b", o_w, o_idx, o_last, e.w, e.idx, e.last);
          end
          if (hsv) begin
            void'(sb.pop_front());
            obs[hs_cnt] = o_w;
            hs_cnt++;
          end
        end
      end
      if (acc) begin
        blk = in_ptr / 16;
        k   = in_ptr % 16;
        sb.push_back(exp_t'{msg[blk][k], 7'(k), 1'b0});
        if (k == 15)
          for (int j = 16; j < rounds; j++) sb.push_back(exp_t'{model[blk][j], 7'(j), (j == rounds - 1)});
        if (in_ptr == 16 && hsv && o_last) b2b_same = 1'b1;
        in_ptr++;
      end
      if (acc) busy_exp = 1'b1;
      else if (hsv && o_last) busy_exp = 1'b0;
      stalled = o_valid && !o_ready;
      hw = o_w; hi = o_idx; hl = o_last;
      @(posedge clk); #1;
      r = rand_ready ? ($urandom_range(0, 1) != 0) : 1'b1;
      if (in_ptr < nblk * 16) drive(1'b1, msg[in_ptr / 16][in_ptr % 16], r);
      else drive(1'b0, 64'h0, r);
    end
    last_cyc = cyc;
    n_checks++;
    if (hs_cnt != nblk * rounds) begin
      n_fail++;
      $display("FAIL handshakes: got %0d, want %0d (cycle budget %0d)", hs_cnt, nblk * rounds, cyc);
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: %0d expected words never produced", sb.size());
    end
    drive(1'b0, 64'h0, 1'b1);
  endtask

  // Runs the abc block on dut32 until W[target] is on the output; returns at that falling edge.
  task automatic run_to_idx(input int target, output bit found);
    int ptr;
    ptr = 0; found = 1'b0;
    drive(1'b1, msg[0][0], 1'b1);
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (out_valid32 && out_idx32 == 7'(target)) found = 1'b1;
      else begin
        if (in_valid32 && in_ready32) ptr++;
        @(posedge clk); #1;
        if (ptr < 16) drive(1'b1, msg[0][ptr], 1'b1);
        else drive(1'b0, 64'h0, 1'b1);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    use64 = 1'b0;
    drive(1'b0, 64'h0, 1'b1);
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({out_valid32, out_w32, out_idx32, out_last32, busy32} !== 41'h0) begin
      n_fail++;
      $display("FAIL reset32: got v=%b w=%h idx=%0d last=%b busy=%b, want all 0", out_valid32, out_w32, out_idx32, out_last32, busy32);
    end
    n_checks++;
    if ({out_valid64, out_w64, out_idx64, out_last64, busy64} !== 73'h0) begin
      n_fail++;
      $display("FAIL reset64: got v=%b w=%h idx=%0d last=%b busy=%b, want all 0", out_valid64, out_w64, out_idx64, out_last64, busy64);
    end
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready32 !== 1'b1 || in_ready64 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b/%b, want 1/1", in_ready32, in_ready64);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_abc();
    use64 = 1'b0;
    load_abc(0, 1'b0);
    build_model(0, 1'b0);
    stream(1, 1'b0);
    n_checks++;
    if (obs[0] !== 64'h61626380 || obs[15] !== 64'h18) begin
      n_fail++;
      $display("FAIL abc_echo: got W0=%h W15=%h, want 61626380/18", obs[0], obs[15]);
    end
    n_checks++;
    if (obs[16] !== 64'h61626380) begin
      n_fail++;
      $display("FAIL abc_w16: got %h, want 61626380", obs[16]);
    end
    n_checks++;
    if (obs[17] !== 64'h000F0000) begin
      n_fail++;
      $display("FAIL abc_w17: got %h, want 000f0000", obs[17]);
    end
    n_checks++;
    if (last_cyc != 65) begin
      n_fail++;
      $display("FAIL abc_latency: got %0d cycles, want 65", last_cyc);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid32 !== 1'b0 || busy32 !== 1'b0 || out_last32 !== 1'b0) begin
      n_fail++;
      $display("FAIL abc_idle: got v=%b busy=%b last=%b, want 0/0/0", out_valid32, busy32, out_last32);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    use64 = 1'b0;
    load_abc(0, 1'b0);
    build_model(0, 1'b0);
    stream(1, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (out_valid32 !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_extra: got out_valid=%b after 64 handshakes, want 0", out_valid32);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    use64 = 1'b0;
    load_abc(0, 1'b0);
    load_random(1);
    build_model(0, 1'b0);
    build_model(1, 1'b0);
    stream(2, 1'b0);
    n_checks++;
    if (b2b_same !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_same_cycle: got %b, want 1", b2b_same);
    end
    n_checks++;
    if (last_cyc != 129) begin
      n_fail++;
      $display("FAIL b2b_latency: got %0d cycles, want 129", last_cyc);
    end
  endtask

  task automatic test_sha512();
    use64 = 1'b1;
    load_abc(0, 1'b1);
    build_model(0, 1'b1);
    stream(1, 1'b0);
    n_checks++;
    if (obs[16] !== 64'h6162638000000000) begin
      n_fail++;
      $display("FAIL sha512_w16: got %h, want 6162638000000000", obs[16]);
    end
    n_checks++;
    if (obs[17] !== 64'h00030000000000C0) begin
      n_fail++;
      $display("FAIL sha512_w17: got %h, want 00030000000000c0", obs[17]);
    end
    n_checks++;
    if (last_cyc != 81) begin
      n_fail++;
      $display("FAIL sha512_latency: got %0d cycles, want 81", last_cyc);
    end
    use64 = 1'b0;
    drive(1'b0, 64'h0, 1'b1);
  endtask

  task automatic test_async_reset();
    bit found;
    use64 = 1'b0;
    load_abc(0, 1'b0);
    build_model(0, 1'b0);
    run_to_idx(30, found);
    n_checks++;
    if (!found || out_w32 !== model[0][30][31:0]) begin
      n_fail++;
      $display("FAIL areset_idx30: found=%b w=%h, want w=%h", found, out_w32, model[0][30][31:0]);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({out_valid32, out_w32, out_idx32, out_last32, busy32} !== 41'h0) begin
      n_fail++;
      $display("FAIL areset_immediate: got v=%b w=%h idx=%0d last=%b busy=%b, want all 0", out_valid32, out_w32, out_idx32, out_last32, busy32);
    end
    drive(1'b0, 64'h0, 1'b1);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    stream(1, 1'b0);
  endtask

`ifdef SHA2_SCHED_ABORT_EN
  task automatic test_abort();
    bit found;
    use64 = 1'b0;
    load_abc(0, 1'b0);
    build_model(0, 1'b0);
    run_to_idx(20, found);
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL abort_reach_idx20: got found=0, want 1");
    end
    abort32 = 1'b1;
    #1;
    n_checks++;
    if (in_ready32 !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_in_ready: got %b during abort, want 0", in_ready32);
    end
    @(posedge clk); #1;
    abort32 = 1'b0;
    n_checks++;
    if (out_valid32 !== 1'b0 || busy32 !== 1'b0 || out_last32 !== 1'b0 || in_ready32 !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_state: got v=%b busy=%b last=%b rdy=%b, want 0/0/0/1", out_valid32, busy32, out_last32, in_ready32);
    end
    stream(1, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_abc();
    test_backpressure();
    test_back_to_back();
    test_sha512();
    test_async_reset();
`ifdef SHA2_SCHED_ABORT_EN
    test_abort();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
